// File: rtl/wbr_ctrl_pkg.sv
// Shared types and safe control levels for WBR chain sequencing.
package wbr_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_IN,
    APPLY,
    SHIFT_OUT,
    DONE
  } state_t;

  // Chain controls whenever no test is in progress: no shifting, core side frozen.
  localparam logic WSE_IDLE  = 1'b0;
  localparam logic HOLD_IDLE = 1'b1;

endpackage

// File: rtl/wbr_seq_counter.sv
// Phase counter: synchronous clear, saturates at the terminal value given by last.
module wbr_seq_counter #(
  parameter int CNT_W = 4
) (
  input  logic             CLK,
  input  logic             resetn,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] last,
  output logic [CNT_W-1:0] count,
  output logic             tc
);

  assign tc = (count == last);

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !tc) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/wbr_scan_sequencer.sv
// Runs one WBR chain through load / apply-capture / unload and returns the unloaded response.
module wbr_scan_sequencer
  import wbr_ctrl_pkg::*;
#(
  parameter int CHAIN_LEN    = 9,
  parameter int APPLY_CYCLES = 1,
  parameter int CNT_W        = $clog2(CHAIN_LEN + APPLY_CYCLES + 1)
) (
  input  logic                 CLK,
  input  logic                 resetn,
  input  logic                 start,
  input  logic                 abort,
  input  logic [CHAIN_LEN-1:0] pattern_in,
  input  logic                 wpso,
  output logic                 wse_inputs,
  output logic                 hold_inputs,
  output logic                 wpsi,
  output logic                 busy,
  output logic                 done,
  output logic [CHAIN_LEN-1:0] response_out
);

  state_t               state;
  logic [CHAIN_LEN-1:0] pat;
  logic [CHAIN_LEN-1:0] resp;
  logic [CHAIN_LEN-1:0] resp_nxt;
  logic [CNT_W-1:0]     count;
  logic [CNT_W-1:0]     last;
  logic                 tc;
  logic                 cnt_clr;
  logic                 cnt_en;

  // Every state change happens either at terminal count, on abort, or out of IDLE/DONE,
  // so clearing on exactly those conditions restarts the counter on each state entry.
  always_comb begin
    last     = (state == APPLY) ? CNT_W'(APPLY_CYCLES - 1) : CNT_W'(CHAIN_LEN - 1);
    cnt_clr  = (state == IDLE) || (state == DONE) || abort || tc;
    cnt_en   = (state == SHIFT_IN) || (state == APPLY) || (state == SHIFT_OUT);
    resp_nxt = {wpso, resp[CHAIN_LEN-1:1]};
  end

  wbr_seq_counter #(.CNT_W(CNT_W)) u_cnt (
    .CLK    (CLK),
    .resetn (resetn),
    .clear  (cnt_clr),
    .enable (cnt_en),
    .last   (last),
    .count  (count),
    .tc     (tc)
  );

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      wse_inputs   <= WSE_IDLE;
      hold_inputs  <= HOLD_IDLE;
      wpsi         <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      response_out <= '0;
      pat          <= '0;
      resp         <= '0;
    end else begin
      done <= 1'b0;
      if (state != IDLE && abort) begin
        state       <= IDLE;
        wse_inputs  <= WSE_IDLE;
        hold_inputs <= HOLD_IDLE;
        wpsi        <= 1'b0;
        busy        <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start && !abort) begin
              state       <= SHIFT_IN;
              wse_inputs  <= 1'b1;
              hold_inputs <= 1'b1;
              wpsi        <= pattern_in[0];
              pat         <= pattern_in >> 1;
              busy        <= 1'b1;
              resp        <= '0;
            end
          end
          SHIFT_IN: begin
            if (tc) begin
              state       <= APPLY;
              wse_inputs  <= 1'b0;
              hold_inputs <= 1'b0;
              wpsi        <= 1'b0;
            end else begin
              wpsi <= pat[0];
              pat  <= pat >> 1;
            end
          end
          APPLY: begin
            if (tc) begin
              state       <= SHIFT_OUT;
              wse_inputs  <= 1'b1;
              hold_inputs <= 1'b1;
            end
          end
          SHIFT_OUT: begin
            // First bit out is the last cell, which lands in resp[0] after all shifts.
            resp <= resp_nxt;
            if (tc) begin
              state        <= DONE;
              wse_inputs   <= WSE_IDLE;
              hold_inputs  <= HOLD_IDLE;
              busy         <= 1'b0;
              done         <= 1'b1;
              response_out <= resp_nxt;
            end
          end
          DONE: begin
            state <= IDLE;
          end
          default: begin
            state       <= IDLE;
            wse_inputs  <= WSE_IDLE;
            hold_inputs <= HOLD_IDLE;
            wpsi        <= 1'b0;
            busy        <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
